// File: rtl/pmem_loader.sv
// Boot-time program loader: receives a length-prefixed byte image, assembles
// little-endian 32-bit words, writes them to program memory from address 0,
// and releases the core from reset once the whole image is in place.
// Optional trailing-checksum verification is enabled by PMEM_LOADER_CHECKSUM_EN.
module pmem_loader #(
    parameter int unsigned AddrWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_data_i,
    output logic                 byte_ready_o,
    input  logic                 start_i,
    output logic                 pmem_we_o,
    output logic [AddrWidth-1:0] pmem_waddr_o,
    output logic [31:0]          pmem_wdata_o,
    output logic                 core_rst_no,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int unsigned ILen     = 32;
    localparam int unsigned AsmW     = ILen - 8;
    localparam int unsigned CntW     = 16;
    localparam int unsigned WordIdxW = AddrWidth - 2;
    localparam int unsigned MaxWords = 2 ** (AddrWidth - 2);

`ifdef PMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERROR
    } state_e;
`endif

    state_e                state_q, state_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [WordIdxW-1:0]   word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [AsmW-1:0]       asm_q, asm_d;
    logic                  we_q, we_d;
    logic [AddrWidth-1:0]  waddr_q, waddr_d;
    logic [ILen-1:0]       wdata_q, wdata_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
`ifdef PMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  accept_c;
    logic [CntW-1:0]       len_c;
    logic                  last_word_c;
    state_e                end_state_c;

    // Loader takes bytes only while parsing the length, data or checksum.
`ifdef PMEM_LOADER_CHECKSUM_EN
    assign byte_ready_o = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                          (state_q == S_DATA) || (state_q == S_CSUM);
    assign end_state_c  = S_CSUM;
`else
    assign byte_ready_o = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                          (state_q == S_DATA);
    assign end_state_c  = S_DONE;
`endif

    assign accept_c    = byte_valid_i && byte_ready_o;
    assign len_c       = {byte_data_i, count_q[7:0]};
    assign last_word_c = (32'(word_idx_q) == (32'(count_q) - 32'd1));

    assign pmem_we_o    = we_q;
    assign pmem_waddr_o = waddr_q;
    assign pmem_wdata_o = wdata_q;
    assign core_rst_no  = core_rst_n_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        core_rst_n_d = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
`ifdef PMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
        if (accept_c) begin
            csum_d = csum_q + byte_data_i;
        end
`endif

        case (state_q)
            S_IDLE: begin
                state_d = S_LEN0;
            end
            S_LEN0: begin
                if (accept_c) begin
                    count_d = {count_q[15:8], byte_data_i};
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept_c) begin
                    count_d = len_c;
                    if (32'(len_c) > MaxWords) begin
                        state_d = S_ERROR;
                    end else if (len_c == '0) begin
                        state_d = end_state_c;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = {byte_data_i, asm_q};
                        waddr_d    = {word_idx_q, 2'b00};
                        word_idx_d = word_idx_q + WordIdxW'(1);
                        byte_idx_d = 2'd0;
                        if (last_word_c) begin
                            state_d = end_state_c;
                        end
                    end else begin
                        asm_d[{byte_idx_q, 3'b000} +: 8] = byte_data_i;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
`ifdef PMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept_c) begin
                    if (8'(csum_q + byte_data_i) == 8'h00) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
`endif
            S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d    = S_LEN0;
                    count_d    = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    asm_d      = '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end else if (state_q == S_DONE) begin
                    done_d       = 1'b1;
                    core_rst_n_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef PMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef PMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

endmodule
